// File: rtl/crosswalk_controller.sv
// -----------------------------------------------------------------------------
// crosswalk_controller
//
// Pedestrian crossing controller for one intersection with two crossings
// (north and west). Each crossing has its own four-state FSM:
//   IDLE -> PENDING (button pressed, asking the sequencer for green)
//        -> WALK    (parallel vehicle green present, walk head lit)
//        -> CLEAR   (clearance interval, then back to IDLE or PENDING)
// Both greens at once is treated as a conflict: a sticky fault forces both
// crossings to IDLE with walk dark and stop lit until reset.
//
// Parameters
//   WALK_SECS   walk-phase length in 1 Hz ticks (1..15)
//   CLEAR_SECS  clearance-phase length in 1 Hz ticks (1..15)
//
// Optional feature (compile-time macro XWALK_FLASH_EN)
//   defined   : stop head flashes during CLEAR, starting lit, toggling per tick
//   undefined : stop head held lit during CLEAR, no flash-phase register
//
// Ports
//   clk_50_mhz                 in   system clock, rising edge
//   reset                      in   synchronous active-high reset
//   tick_1hz                   in   one-cycle enable pulse per second
//   nrth_xwalk_sig/west_..     in   debounced pedestrian buttons (level)
//   grn/ylw/red_nrth/_west     in   vehicle light states
//   walk_light_nrth/_west      out  pedestrian walk heads
//   stop_light_nrth/_west      out  pedestrian stop heads
//   xwalk_req_nrth/_west       out  pending request to the sequencer
//   fault                      out  sticky green/green conflict indicator
// -----------------------------------------------------------------------------
module crosswalk_controller #(
    parameter int WALK_SECS  = 7,
    parameter int CLEAR_SECS = 5
) (
    input  logic clk_50_mhz,
    input  logic reset,
    input  logic tick_1hz,
    input  logic nrth_xwalk_sig,
    input  logic west_xwalk_sig,
    input  logic grn_nrth,
    input  logic ylw_nrth,
    input  logic red_nrth,
    input  logic grn_west,
    input  logic ylw_west,
    input  logic red_west,
    output logic walk_light_nrth,
    output logic stop_light_nrth,
    output logic walk_light_west,
    output logic stop_light_west,
    output logic xwalk_req_nrth,
    output logic xwalk_req_west,
    output logic fault
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_WALK    = 2'd2,
        ST_CLEAR   = 2'd3
    } state_e;

    localparam logic [3:0] WALK_LOAD  = 4'(WALK_SECS);
    localparam logic [3:0] CLEAR_LOAD = 4'(CLEAR_SECS);

    // Index 0 = north crossing, index 1 = west crossing.
    state_e     state_q [2];
    state_e     state_d [2];
    logic [3:0] cnt_q   [2];
    logic [3:0] cnt_d   [2];
    logic [1:0] defer_q;
    logic [1:0] defer_d;
    logic [1:0] lvl_q;
    logic [1:0] prev_q;
    logic       fault_q;
    logic       fault_d;

    logic [1:0] grn_s;
    logic [1:0] press_s;
    logic       conflict_s;
    logic [1:0] walk_s;
    logic [1:0] stop_s;
    logic [1:0] req_s;

    // Amber and red states are not needed by this controller.
    logic unused_lights_s;
    assign unused_lights_s = ylw_nrth ^ red_nrth ^ ylw_west ^ red_west;

    assign grn_s      = {grn_west, grn_nrth};
    // A press is a rising edge of the registered button level, so a held
    // button produces exactly one press.
    assign press_s    = lvl_q & ~prev_q;
    assign conflict_s = grn_s[0] & grn_s[1];
    assign fault_d    = fault_q | conflict_s;

`ifdef XWALK_FLASH_EN
    logic [1:0] flash_q;
    logic [1:0] flash_d;

    // Flash phase: lit on CLEAR entry, toggled on every tick while in CLEAR.
    always_comb begin
        flash_d = flash_q;
        for (int d = 0; d < 2; d++) begin
            if (state_d[d] == ST_CLEAR && state_q[d] != ST_CLEAR) begin
                flash_d[d] = 1'b1;
            end else if (state_q[d] == ST_CLEAR && tick_1hz) begin
                flash_d[d] = ~flash_q[d];
            end else begin
                flash_d[d] = flash_q[d];
            end
        end
    end

    // Flash-phase register.
    always_ff @(posedge clk_50_mhz) begin
        if (reset) begin
            flash_q <= 2'b00;
        end else begin
            flash_q <= flash_d;
        end
    end
`endif

    // Next-state, counter and deferred-request logic for both crossings.
    // A press is always judged against the current (old) state, so a press in
    // the cycle CLEAR expires still turns into a deferred request.
    always_comb begin
        defer_d = defer_q;
        for (int d = 0; d < 2; d++) begin
            state_d[d] = state_q[d];
            cnt_d[d]   = cnt_q[d];
            if (fault_q || conflict_s) begin
                // Conflict lockout: park in IDLE until reset.
                state_d[d] = ST_IDLE;
                cnt_d[d]   = 4'd0;
                defer_d[d] = 1'b0;
            end else begin
                case (state_q[d])
                    ST_IDLE: begin
                        if (press_s[d]) begin
                            state_d[d] = ST_PENDING;
                        end else begin
                            state_d[d] = ST_IDLE;
                        end
                    end
                    ST_PENDING: begin
                        if (grn_s[d]) begin
                            state_d[d] = ST_WALK;
                            cnt_d[d]   = WALK_LOAD;
                        end else begin
                            state_d[d] = ST_PENDING;
                        end
                    end
                    ST_WALK: begin
                        if (!grn_s[d]) begin
                            // Green withdrawn: abort straight into clearance.
                            state_d[d] = ST_CLEAR;
                            cnt_d[d]   = CLEAR_LOAD;
                        end else if (tick_1hz && cnt_q[d] == 4'd1) begin
                            state_d[d] = ST_CLEAR;
                            cnt_d[d]   = CLEAR_LOAD;
                        end else if (tick_1hz && cnt_q[d] != 4'd0) begin
                            cnt_d[d] = cnt_q[d] - 4'd1;
                        end else begin
                            cnt_d[d] = cnt_q[d];
                        end
                    end
                    ST_CLEAR: begin
                        if (press_s[d]) begin
                            defer_d[d] = 1'b1;
                        end else begin
                            defer_d[d] = defer_q[d];
                        end
                        if (tick_1hz && cnt_q[d] == 4'd1) begin
                            if (defer_q[d] || press_s[d]) begin
                                state_d[d] = ST_PENDING;
                            end else begin
                                state_d[d] = ST_IDLE;
                            end
                            cnt_d[d]   = 4'd0;
                            defer_d[d] = 1'b0;
                        end else if (tick_1hz && cnt_q[d] != 4'd0) begin
                            cnt_d[d] = cnt_q[d] - 4'd1;
                        end else begin
                            cnt_d[d] = cnt_q[d];
                        end
                    end
                    default: begin
                        state_d[d] = ST_IDLE;
                        cnt_d[d]   = 4'd0;
                        defer_d[d] = 1'b0;
                    end
                endcase
            end
        end
    end

    // State, counter, flag, edge-detect and fault registers.
    always_ff @(posedge clk_50_mhz) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                state_q[d] <= ST_IDLE;
                cnt_q[d]   <= 4'd0;
            end
            defer_q <= 2'b00;
            lvl_q   <= 2'b00;
            prev_q  <= 2'b00;
            fault_q <= 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                state_q[d] <= state_d[d];
                cnt_q[d]   <= cnt_d[d];
            end
            defer_q <= defer_d;
            lvl_q   <= {west_xwalk_sig, nrth_xwalk_sig};
            prev_q  <= lvl_q;
            fault_q <= fault_d;
        end
    end

    // Pedestrian head decode. Walk is gated by live green so it goes dark in
    // the very cycle green is withdrawn.
    always_comb begin
        walk_s = 2'b00;
        stop_s = 2'b11;
        req_s  = 2'b00;
        for (int d = 0; d < 2; d++) begin
            if (fault_q) begin
                walk_s[d] = 1'b0;
                stop_s[d] = 1'b1;
                req_s[d]  = 1'b0;
            end else begin
                walk_s[d] = (state_q[d] == ST_WALK) && grn_s[d];
                req_s[d]  = (state_q[d] == ST_PENDING);
                case (state_q[d])
                    ST_IDLE:    stop_s[d] = 1'b1;
                    ST_PENDING: stop_s[d] = 1'b1;
                    ST_WALK:    stop_s[d] = 1'b0;
`ifdef XWALK_FLASH_EN
                    ST_CLEAR:   stop_s[d] = flash_q[d];
`else
                    ST_CLEAR:   stop_s[d] = 1'b1;
`endif
                    default:    stop_s[d] = 1'b1;
                endcase
            end
        end
    end

    assign walk_light_nrth = walk_s[0];
    assign walk_light_west = walk_s[1];
    assign stop_light_nrth = stop_s[0];
    assign stop_light_west = stop_s[1];
    assign xwalk_req_nrth  = req_s[0];
    assign xwalk_req_west  = req_s[1];
    assign fault           = fault_q;

endmodule

// File: tb/tb_crosswalk_controller.sv
module tb_crosswalk_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic n_btn = 1'b0;
    logic w_btn = 1'b0;
    logic gn = 1'b0;
    logic gw = 1'b0;
    logic walk_n, stop_n, walk_w, stop_w, req_n, req_w, flt;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    crosswalk_controller #(.WALK_SECS(7), .CLEAR_SECS(5)) dut (
        .clk_50_mhz      (clk),
        .reset           (rst),
        .tick_1hz        (tick),
        .nrth_xwalk_sig  (n_btn),
        .west_xwalk_sig  (w_btn),
        .grn_nrth        (gn),
        .ylw_nrth        (1'b0),
        .red_nrth        (~gn),
        .grn_west        (gw),
        .ylw_west        (1'b0),
        .red_west        (~gw),
        .walk_light_nrth (walk_n),
        .stop_light_nrth (stop_n),
        .walk_light_west (walk_w),
        .stop_light_west (stop_w),
        .xwalk_req_nrth  (req_n),
        .xwalk_req_west  (req_w),
        .fault           (flt)
    );

    // Observed vector: {walk_n, stop_n, req_n, walk_w, stop_w, req_w, fault}
    logic [6:0] obs;
    assign obs = {walk_n, stop_n, req_n, walk_w, stop_w, req_w, flt};

    localparam logic [6:0] IDLE  = 7'b0100100;
    localparam logic [6:0] NP    = 7'b0110100;
    localparam logic [6:0] NW    = 7'b1000100;
    localparam logic [6:0] WP    = 7'b0100110;
    localparam logic [6:0] WW    = 7'b0101000;
    localparam logic [6:0] FAULT = 7'b0100101;

    // Expected stop head after i ticks spent in CLEAR.
    function automatic logic clr_stop(input int i);
`ifdef XWALK_FLASH_EN
        return ~i[0];
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [6:0] nc(input int i);
        return {1'b0, clr_stop(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    endfunction

    function automatic logic [6:0] wc(input int i);
        return {1'b0, 1'b1, 1'b0, 1'b0, clr_stop(i), 1'b0, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic check(input string tag, input logic [6:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    initial begin
        // Reset for three cycles, then idle.
        step(); step(); step();
        rst = 1'b0;
        check("reset_state", IDLE);
        step();
        check("idle_after_reset", IDLE);

        // North full cycle; button held throughout.
        n_btn = 1'b1;
        step();
        check("n_press_latency", IDLE);
        step();
        check("n_req_cycle1", NP);
        step();
        check("n_req_cycle2", NP);
        gn = 1'b1;
        step();
        check("n_walk_entry", NW);
        for (int i = 1; i <= 7; i++) begin
            pulse_tick();
            if (i < 7) check("n_walk_tick", NW);
            else       check("n_walk_to_clear", nc(0));
        end
        gn = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            pulse_tick();
            if (i < 5) check("n_clear_tick", nc(i));
            else       check("n_clear_to_idle", IDLE);
        end
        for (int i = 0; i < 8; i++) begin
            pulse_tick();
            check("n_held_no_rereq", IDLE);
        end
        n_btn = 1'b0;
        step();

        // North abort after three walk ticks.
        n_btn = 1'b1;
        step(); step();
        check("ab_req", NP);
        n_btn = 1'b0;
        gn = 1'b1;
        step();
        check("ab_walk", NW);
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            check("ab_walk_tick", NW);
        end
        gn = 1'b0;
        #1;
        check("ab_walk_dark_same_cycle", 7'b0000100);
        step();
        check("ab_clear_entry", nc(0));
        for (int i = 1; i <= 5; i++) begin
            pulse_tick();
            if (i < 5) check("ab_clear_tick", nc(i));
            else       check("ab_idle", IDLE);
        end

        // West press during CLEAR is deferred straight to PENDING.
        w_btn = 1'b1;
        step(); step();
        check("w_req", WP);
        gw = 1'b1;
        w_btn = 1'b0;
        step();
        check("w_walk", WW);
        gw = 1'b0;
        step();
        check("w_clear_entry", wc(0));
        pulse_tick();
        check("w_clear_tick1", wc(1));
        w_btn = 1'b1;
        step(); step();
        check("w_press_in_clear", wc(1));
        w_btn = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            pulse_tick();
            if (i < 5) check("w_clear_tick", wc(i));
            else       check("w_deferred_req", WP);
        end
        gw = 1'b1;
        step();
        check("w_walk2", WW);
        gw = 1'b0;
        step();
        for (int i = 1; i <= 5; i++) pulse_tick();
        check("w_back_idle", IDLE);

        // Green/green conflict during north WALK.
        n_btn = 1'b1;
        step(); step();
        check("f_req", NP);
        n_btn = 1'b0;
        gn = 1'b1;
        step();
        check("f_walk", NW);
        gw = 1'b1;
        #1;
        check("f_conflict_cycle", NW);
        step();
        check("f_fault_set", FAULT);
        gw = 1'b0;
        w_btn = 1'b1;
        pulse_tick();
        step(); step();
        check("f_fault_hold", FAULT);
        w_btn = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("f_cleared_by_reset", IDLE);
        gn = 1'b0;

        // Reset mid-WALK aborts with no clearance.
        n_btn = 1'b1;
        step(); step();
        check("r_req", NP);
        n_btn = 1'b0;
        gn = 1'b1;
        step();
        pulse_tick();
        check("r_walk", NW);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("r_idle_now", IDLE);
        step();
        check("r_idle_stays", IDLE);
        gn = 1'b0;

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
